// File: rtl/odo_result_to_host.sv
// Queues winning results (seq, nonce, hash) in a small record FIFO and streams
// each record to the host as 32-bit words over a valid/ready handshake.
module odo_result_to_host #(
  parameter int unsigned HASH_WORDS = 2,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk_h,
  input  logic                  rst_n,
  input  logic                  ticket2moon,
  input  logic [31:0]           nonce_in,
  input  logic [255:0]          hash_in,
  input  logic                  host_ready_in,
  input  logic                  clr_overflow_in,
  output logic [31:0]           data_to_host_out,
  output logic                  data_valid_out,
  output logic                  last_word_out,
  output logic [DEPTH_LOG2:0]   results_pending_out,
  output logic                  overflow_out
);

  localparam int unsigned NWORDS = 2 + HASH_WORDS;
  localparam int unsigned WW     = $clog2(NWORDS);
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CW     = DEPTH_LOG2 + 1;
  localparam int unsigned PAY_W  = 32 * (1 + HASH_WORDS);
  localparam int unsigned REC_W  = 8 + PAY_W;
  localparam logic [WW-1:0] LAST_W = WW'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [WW-1:0]           w_q, w_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [7:0]              seq_q, seq_d;
  logic                    overflow_q, overflow_d;
  logic [31:0]             data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [REC_W-1:0]        mem_q [DEPTH];

  logic                    hs, pop, push, drop, full;
  logic [REC_W-1:0]        new_rec, head_rec;
  logic                    unused_hash;

  // Only the top HASH_WORDS words of the hash are forwarded.
  assign unused_hash = ^{hash_in, 1'b0};
  assign new_rec     = {seq_q, nonce_in, hash_in[255 -: 32*HASH_WORDS]};

  // Word w of a record: header, nonce, then hash words MS first.
  function automatic logic [31:0] rec_word(input logic [REC_W-1:0] rec,
                                           input logic [WW-1:0] w);
    logic [31:0] word;
    word = {16'hA55A, rec[REC_W-1 -: 8], 8'(NWORDS)};
    for (int unsigned j = 0; j < 1 + HASH_WORDS; j++) begin
      if (w == WW'(j + 1)) word = rec[PAY_W-1-32*j -: 32];
    end
    return word;
  endfunction

  always_comb begin
    state_d    = state_q;
    w_d        = w_q;
    hs         = (state_q == SEND) && host_ready_in;
    pop        = hs && (w_q == LAST_W);
    full       = (count_q == CW'(DEPTH));
    push       = ticket2moon && (!full || pop);
    drop       = ticket2moon && full && !pop;
    count_d    = count_q + CW'(push) - CW'(pop);
    rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
    wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
    seq_d      = seq_q + 8'(ticket2moon);
    overflow_d = drop | (overflow_q & ~clr_overflow_in);

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = SEND;
          w_d     = '0;
        end
      end
      SEND: begin
        if (hs) begin
          if (pop) begin
            w_d = '0;
            if (count_d == '0) state_d = IDLE;
          end else begin
            w_d = w_q + WW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A record written this edge into an otherwise drained FIFO is forwarded directly.
    head_rec = (push && (wr_ptr_q == rd_ptr_d)) ? new_rec : mem_q[rd_ptr_d];
    valid_d  = (state_d == SEND);
    data_d   = valid_d ? rec_word(head_rec, w_d) : 32'h0;
    last_d   = valid_d && (w_d == LAST_W);
  end

  always_ff @(posedge clk_h) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      w_q        <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_q        <= w_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      if (push) mem_q[wr_ptr_q] <= new_rec;
    end
  end

  assign data_to_host_out    = data_q;
  assign data_valid_out      = valid_q;
  assign last_word_out       = last_q;
  assign results_pending_out = count_q;
  assign overflow_out        = overflow_q;

endmodule
